// File: rtl/mem_access_unit.sv
// Load/store initiator for the internal RAM request/valid interface.
// Handles one access at a time: check, issue a single-cycle RAM enable, extend the load data and respond.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter bit          CHECK_ALIGN    = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic [1:0]  o_resp_err,
    output logic        o_mem_enable,
    output logic [24:0] o_mem_addr,
    output logic [1:0]  o_mem_oplen,
    output logic        o_mem_we,
    output logic [31:0] o_mem_data,
    input  logic [31:0] i_mem_result,
    input  logic        i_mem_valid
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ErrOk       = 2'b00;
    localparam logic [1:0] ErrAlign    = 2'b01;
    localparam logic [1:0] ErrIllegal  = 2'b10;
    localparam logic [1:0] ErrTimeout  = 2'b11;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e            r_state;
    logic [CntW-1:0]   r_cnt;
    logic [2:0]        r_funct3;
    logic              r_req_ready;
    logic              r_resp_valid;
    logic [31:0]       r_resp_rdata;
    logic [1:0]        r_resp_err;
    logic              r_mem_enable;
    logic [24:0]       r_mem_addr;
    logic [1:0]        r_mem_oplen;
    logic              r_mem_we;
    logic [31:0]       r_mem_data;

    logic              w_f3_legal;
    logic              w_addr_bad;
    logic              w_misalign;
    logic [1:0]        w_err;
    logic [1:0]        w_oplen;
    logic [31:0]       w_wdata;
    logic [31:0]       w_load_data;

    // Request checks, evaluated on the live request while idle.
    always_comb begin
        w_f3_legal = 1'b0;
        if (i_req_we) begin
            unique case (i_req_funct3)
                3'b000, 3'b001, 3'b010: w_f3_legal = 1'b1;
                default:                w_f3_legal = 1'b0;
            endcase
        end else begin
            unique case (i_req_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_f3_legal = 1'b1;
                default:                                w_f3_legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_addr_bad = |i_req_addr[31:25];
        w_misalign = 1'b0;
        if (CHECK_ALIGN) begin
            w_misalign = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
                         ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
        end
        if (!w_f3_legal || w_addr_bad) begin
            w_err = ErrIllegal;
        end else if (w_misalign) begin
            w_err = ErrAlign;
        end else begin
            w_err = ErrOk;
        end
    end

    always_comb begin
        w_oplen = 2'b11;
        w_wdata = i_req_wdata;
        unique case (i_req_funct3[1:0])
            2'b00: begin
                w_oplen = 2'b00;
                w_wdata = {24'h0, i_req_wdata[7:0]};
            end
            2'b01: begin
                w_oplen = 2'b01;
                w_wdata = {16'h0, i_req_wdata[15:0]};
            end
            default: begin
                w_oplen = 2'b11;
                w_wdata = i_req_wdata;
            end
        endcase
    end

    always_comb begin
        w_load_data = i_mem_result;
        unique case (r_funct3)
            3'b000:  w_load_data = {{24{i_mem_result[7]}}, i_mem_result[7:0]};
            3'b001:  w_load_data = {{16{i_mem_result[15]}}, i_mem_result[15:0]};
            3'b100:  w_load_data = {24'h0, i_mem_result[7:0]};
            3'b101:  w_load_data = {16'h0, i_mem_result[15:0]};
            default: w_load_data = i_mem_result;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_funct3     <= 3'b000;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_resp_err   <= ErrOk;
            r_mem_enable <= 1'b0;
            r_mem_addr   <= 25'h0;
            r_mem_oplen  <= 2'b00;
            r_mem_we     <= 1'b0;
            r_mem_data   <= 32'h0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_resp_err   <= ErrOk;
            r_mem_enable <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_req_valid) begin
                        r_req_ready <= 1'b0;
                        r_funct3    <= i_req_funct3;
                        if (w_err != ErrOk) begin
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= w_err;
                            r_state      <= StResp;
                        end else begin
                            r_mem_enable <= 1'b1;
                            r_mem_addr   <= i_req_addr[24:0];
                            r_mem_oplen  <= w_oplen;
                            r_mem_we     <= i_req_we;
                            r_mem_data   <= w_wdata;
                            r_state      <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    r_cnt   <= '0;
                    r_state <= StWait;
                end
                StWait: begin
                    // A completion arriving on the final wait cycle still beats the timeout.
                    if (i_mem_valid) begin
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= r_mem_we ? 32'h0 : w_load_data;
                        r_state      <= StResp;
                    end else if (r_cnt == CntLast) begin
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= ErrTimeout;
                        r_state      <= StResp;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StResp: begin
                    r_req_ready <= 1'b1;
                    r_state     <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_req_ready  = r_req_ready;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_rdata = r_resp_rdata;
    assign o_resp_err   = r_resp_err;
    assign o_mem_enable = r_mem_enable;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_oplen  = r_mem_oplen;
    assign o_mem_we     = r_mem_we;
    assign o_mem_data   = r_mem_data;

endmodule
